// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the two-master native memory bus arbiter.
// State encodings and the read data returned on a forced completion.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_BUSY    = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-input round-robin pick: a lone request wins outright,
// a tie goes to whichever master did not own the bus last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       owner,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        owner   = 1'b0;
        unique case (req)
            2'b01:   owner = 1'b0;
            2'b10:   owner = 1'b1;
            2'b11:   owner = ~last_owner;
            default: owner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the native memory bus with
// round-robin grant, a mandatory release cycle and an access timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int                 DATA_W       = 32,
    parameter int                 TIMEOUT      = 255,
    parameter int                 TO_W         = 8,
    parameter logic [DATA_W-1:0]  TIMEOUT_DATA = ARB_TIMEOUT_DATA
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m0_valid,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_wen,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_wen,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_valid,
    output logic [DATA_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [3:0]        s_wen,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,

    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_owner_q, last_owner_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic              pick_owner;
    logic              any_req;
    logic              busy;
    logic              own_valid;
    logic              done;
    logic              to_fire;
    logic              own_ready;
    logic [DATA_W-1:0] own_rdata;

    rr_pick2 u_pick (
        .req        ({m1_valid, m0_valid}),
        .last_owner (last_owner_q),
        .owner      (pick_owner),
        .any_req    (any_req)
    );

    always_comb begin
        busy      = (state_q == ARB_BUSY);
        own_valid = owner_q ? m1_valid : m0_valid;

        s_valid = busy & own_valid;
        s_addr  = '0;
        s_wdata = '0;
        s_wen   = '0;
        if (busy) begin
            s_addr  = owner_q ? m1_addr  : m0_addr;
            s_wdata = owner_q ? m1_wdata : m0_wdata;
            s_wen   = owner_q ? m1_wen   : m0_wen;
        end

        // A real s_ready in the timeout cycle takes priority.
        done      = s_valid & s_ready;
        to_fire   = s_valid & ~s_ready & (to_cnt_q == TO_LAST);
        own_ready = done | to_fire;
        own_rdata = to_fire ? TIMEOUT_DATA : s_rdata;

        m0_ready = own_ready & ~owner_q;
        m1_ready = own_ready &  owner_q;
        m0_rdata = (busy & ~owner_q) ? own_rdata : '0;
        m1_rdata = (busy &  owner_q) ? own_rdata : '0;

        grant       = busy ? {owner_q, ~owner_q} : 2'b00;
        timeout_err = to_fire;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        to_cnt_d     = to_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    owner_d  = pick_owner;
                    to_cnt_d = '0;
                    state_d  = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!own_valid) begin
                    state_d = ARB_RELEASE;
                end else if (own_ready) begin
                    last_owner_d = owner_q;
                    state_d      = ARB_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grant order, forwarding,
// release gap, timeout and mid-transaction reset.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wen, m1_wen;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wen;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wen      (m0_wen),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wen      (m1_wen),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wen       (s_wen),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wen = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wen = 0;
        s_ready  = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        step();
        step();
        resetn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        s_rdata = 32'h1111_2222;
        do_reset();
        #1;
        checks++;
        if ({s_valid, grant, m0_ready, m1_ready, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {s_valid, grant, m0_ready, m1_ready, timeout_err});
        end
        checks++;
        if ({m0_rdata, m1_rdata, s_addr} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0",
                     m0_rdata, m1_rdata, s_addr);
        end
        s_rdata = 0;
    endtask

    task automatic test_m0_read();
        m0_valid = 1; m0_addr = 32'h2040_0000; m0_wen = 0;
        #1;
        checks++;
        if (s_valid !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL m0rd_idle s_valid %b grant %b want 0 00", s_valid, grant);
        end
        step();
        checks++;
        if (s_valid !== 1'b1 || grant !== 2'b01 || s_addr !== 32'h2040_0000) begin
            errors++;
            $display("FAIL m0rd_busy s_valid %b grant %b addr %h want 1 01 20400000",
                     s_valid, grant, s_addr);
        end
        step();
        checks++;
        if (m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL m0rd_wait m0_ready %b want 0", m0_ready);
        end
        step();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL m0rd_done ready %b rdata %h m1_ready %b want 1 12345678 0",
                     m0_ready, m0_rdata, m1_ready);
        end
        step();
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        #1;
        checks++;
        if (s_valid !== 1'b0 || grant !== 2'b00 || m0_ready !== 1'b0 || s_addr !== 0) begin
            errors++;
            $display("FAIL m0rd_release s_valid %b grant %b ready %b addr %h want 0 00 0 0",
                     s_valid, grant, m0_ready, s_addr);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        int         n;
        idle_inputs();
        m0_valid = 1; m0_addr = 32'h100;
        m1_valid = 1; m1_addr = 32'h200;
        s_ready  = 1; s_rdata = 32'h55;
        do_reset();
        exp_g  = 2'b01;
        prev_g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            #1;
            while (grant === 2'b00 && n < 6) begin
                step();
                n++;
            end
            checks++;
            if (grant !== exp_g || grant === prev_g) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b", i, grant, exp_g);
            end
            checks++;
            if ({m1_ready, m0_ready} !== exp_g) begin
                errors++;
                $display("FAIL rr_ready%0d got %b want %b", i, {m1_ready, m0_ready}, exp_g);
            end
            prev_g = grant;
            exp_g  = ~exp_g;
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_m1_write();
        int m0_hits = 0;
        step();
        m1_valid = 1; m1_addr = 32'h3000_0000; m1_wdata = 32'hA5; m1_wen = 4'hF;
        step();
        checks++;
        if (grant !== 2'b10 || s_wen !== 4'hF || s_wdata !== 32'hA5 ||
            s_addr !== 32'h3000_0000) begin
            errors++;
            $display("FAIL m1wr_mux grant %b wen %h wdata %h addr %h want 10 f a5 30000000",
                     grant, s_wen, s_wdata, s_addr);
        end
        if (m0_ready) m0_hits++;
        s_ready = 1;
        #1;
        if (m0_ready) m0_hits++;
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL m1wr_done ready %b rdata %h want 1 0", m1_ready, m1_rdata);
        end
        step();
        idle_inputs();
        #1;
        if (m0_ready) m0_hits++;
        step();
        if (m0_ready) m0_hits++;
        checks++;
        if (m0_hits !== 0) begin
            errors++;
            $display("FAIL m1wr_m0idle m0_ready seen %0d times want 0", m0_hits);
        end
    endtask

    task automatic test_timeout();
        int n;
        int early_err = 0;
        m0_valid = 1; m0_addr = 32'h5000_0000;
        step();
        m1_valid = 1; m1_addr = 32'h6000_0000;
        n = 1;
        #1;
        while (!m0_ready && n < 300) begin
            if (timeout_err) early_err++;
            step();
            n++;
        end
        checks++;
        if (n !== 255) begin
            errors++;
            $display("FAIL to_cycles got %0d want 255", n);
        end
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF ||
            timeout_err !== 1'b1 || early_err !== 0) begin
            errors++;
            $display("FAIL to_done ready %b rdata %h err %b early %0d want 1 deadbeef 1 0",
                     m0_ready, m0_rdata, timeout_err, early_err);
        end
        step();
        m0_valid = 0;
        #1;
        checks++;
        if (timeout_err !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse err %b s_valid %b want 0 0", timeout_err, s_valid);
        end
        step();
        step();
        checks++;
        if (grant !== 2'b10 || s_addr !== 32'h6000_0000) begin
            errors++;
            $display("FAIL to_next grant %b addr %h want 10 60000000", grant, s_addr);
        end
        s_ready = 1;
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_to_coincide();
        m0_valid = 1; m0_addr = 32'h5000_0004;
        step();
        for (int i = 0; i < 254; i++) step();
        s_ready = 1; s_rdata = 32'h0BAD_F00D;
        #1;
        checks++;
        if (m0_ready !== 1'b1 || timeout_err !== 1'b0 || m0_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL to_coincide ready %b err %b rdata %h want 1 0 0badf00d",
                     m0_ready, timeout_err, m0_rdata);
        end
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset_busy();
        m0_valid = 1; m0_addr = 32'h700;
        step();
        m1_valid = 1; m1_addr = 32'h800;
        s_rdata = 32'h7777;
        #1;
        checks++;
        if (grant !== 2'b01 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstb_pre grant %b s_valid %b want 01 1", grant, s_valid);
        end
        resetn = 0;
        step();
        resetn = 1;
        #1;
        checks++;
        if (s_valid !== 1'b0 || grant !== 2'b00 || m0_ready !== 1'b0 ||
            m1_ready !== 1'b0 || m0_rdata !== 0 || m1_rdata !== 0) begin
            errors++;
            $display("FAIL rstb_clear s_valid %b grant %b rdy %b%b rd %h %h want 0 00 00 0 0",
                     s_valid, grant, m1_ready, m0_ready, m0_rdata, m1_rdata);
        end
        step();
        checks++;
        if (grant !== 2'b01 || s_addr !== 32'h700) begin
            errors++;
            $display("FAIL rstb_tie grant %b addr %h want 01 00000700", grant, s_addr);
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        test_reset();
        test_m0_read();
        test_round_robin();
        test_m1_write();
        test_timeout();
        test_to_coincide();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the leiwand_rv32 native memory bus (valid/ready/addr/wdata/wen/rdata).
- Lets a second master (DMA or debug loader) share the SoC address-decoded memory fabric with the CPU core. It sits between the masters and the existing decoder/ready-mux.
- Grants round-robin, holds the grant until the slave completes, enforces one idle cycle between transactions, and terminates hung accesses with a timeout.

Parameters:
- DATA_W, 32, data and address width (equals MEM_WIDTH).
- TIMEOUT, 255, max cycles in a grant without s_ready before forced completion (1..2^TO_W-1).
- TO_W, 8, timeout counter width.
- TIMEOUT_DATA, 32'hDEAD_BEEF, rdata returned to the master on timeout.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset: synchronous, active-low.
- m0_valid  in  1  CPU request; held with its fields stable until m0_ready.
- m0_addr / m0_wdata  in  DATA_W each  CPU address / write data.
- m0_wen  in  4  CPU byte write enables; 0 means read.
- m0_ready  out  1  CPU transfer complete.
- m0_rdata  out  DATA_W  CPU read data.
- m1_valid, m1_addr, m1_wdata, m1_wen, m1_ready, m1_rdata: same as the m0 ports, for the second master.
- s_valid  out  1  request to the slave fabric.
- s_addr / s_wdata  out  DATA_W each  muxed address / write data.
- s_wen  out  4  muxed byte enables.
- s_ready  in  1  slave complete.
- s_rdata  in  DATA_W  slave read data.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  one-cycle pulse on a forced completion.

Behaviour:
- States: IDLE, BUSY, RELEASE. Registers: state, owner (1 bit), last_owner (1 bit), to_cnt (TO_W bits).
- Reset (resetn=0 at a clk edge), including mid-transaction:
  - state=IDLE, grant=00, s_valid=0, m0_ready=m1_ready=0, timeout_err=0, to_cnt=0.
  - last_owner=1, so m0 wins the first tie.
  - m*_rdata outputs are 0.
- IDLE:
  - Only m0_valid: owner=0. Only m1_valid: owner=1.
  - Both: owner = ~last_owner.
  - On any request: go to BUSY and clear to_cnt. With no request, stay in IDLE.
- BUSY:
  - s_valid=1. s_addr/s_wdata/s_wen come combinationally from the owner. grant is one-hot for the owner.
  - The non-owner sees ready=0, and its request is held pending.
  - s_ready is forwarded combinationally to the owner's ready, and s_rdata to the owner's rdata, in the same cycle.
  - On s_ready: last_owner=owner, go to RELEASE.
  - On to_cnt==TIMEOUT-1 with no s_ready:
    - Owner ready=1, owner rdata=TIMEOUT_DATA, timeout_err=1 for exactly that cycle.
    - last_owner=owner, go to RELEASE.
    - If s_ready arrives in the same cycle, the normal completion wins: no error, and s_rdata is returned.
  - Otherwise to_cnt increments.
  - If the owner drops valid while in BUSY (protocol violation): abort to RELEASE with no ready pulse and no error.
- RELEASE:
  - One cycle: s_valid=0, grant=00, all readies 0, then go to IDLE.
  - This guarantees an s_valid gap, so registered slave readies cannot double-fire.
- Latency: request seen in IDLE at cycle N; s_valid high from N+1; slave ready at N+1+k gives master ready at N+1+k.
  - Back-to-back completion→next grant: minimum 2 idle cycles (RELEASE, IDLE).
- Fairness: with both masters continuously requesting, grants strictly alternate. Neither waits more than one foreign transaction.
- Non-owner outputs: ready=0, rdata=0.
- s_addr/s_wdata/s_wen are 0 when not in BUSY.
- No address decoding is done here; the downstream decoder is unchanged.

Decomposition:
- leiwand_rv32_constants gains ARB_IDLE/ARB_BUSY/ARB_RELEASE state encodings and the TIMEOUT_DATA default.
- One natural sub-module: rr_pick2. It is combinational plus a last_owner input; it returns owner and any_req. It is reusable for future extra masters.

Test Plan:
- m0 only: read 0x20400000, slave ready 2 cycles after s_valid → m0_ready 1 cycle, m0_rdata = s_rdata (0x12345678), grant=01 only in BUSY, s_valid low in RELEASE.
- Both request from reset, each slave access 1 cycle, 4 transactions per master → grant sequence 01,10,01,10,…; m0 served first; no master has 2 consecutive grants.
- m1 write 0x30000000, wdata 0xA5, wen 4'hF, while m0 is idle → s_wen=F, s_wdata=0xA5; m0_ready never asserts.
- m0 to an unmapped address (0x50000000), s_ready never asserted → after exactly TIMEOUT (255) BUSY cycles: m0_ready=1, m0_rdata=0xDEADBEEF, timeout_err 1-cycle pulse; next grant goes to m1 if pending.
- s_ready coincides with the timeout cycle → normal completion, timeout_err=0, rdata=s_rdata.
- resetn low during BUSY → next cycle s_valid=0, grant=00, readies 0. After release, a pending m1 and m0 tie goes to m0.
